// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: load/alarm controls and time/status outputs of the timekeeper
interface rtc_timekeeper_if;
  logic [4:0] initial_time_hh;
  logic [5:0] initial_time_mm;
  logic [5:0] initial_time_ss;
  logic       initial_time_valid;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_valid;
  logic       alarm_en;
  logic       alarm_clear;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       pm;
  logic       sec_pulse;
  logic       alarm;
  logic       load_err;
  modport master (
    output initial_time_hh, initial_time_mm, initial_time_ss, initial_time_valid,
    output alarm_hh, alarm_mm, alarm_valid, alarm_en, alarm_clear,
    input  hh, mm, ss, pm, sec_pulse, alarm, load_err
  );
  modport slave (
    input  initial_time_hh, initial_time_mm, initial_time_ss, initial_time_valid,
    input  alarm_hh, alarm_mm, alarm_valid, alarm_en, alarm_clear,
    output hh, mm, ss, pm, sec_pulse, alarm, load_err
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: seconds prescaler, 24-hour time of day, alarm with auto-stop ring
module rtc_timekeeper #(
  parameter int TICK_DIV  = 50000000,
  parameter int MODE12    = 0,
  parameter int ALARM_LEN = 60
) (
  input logic            clk,
  input logic            rst_n,
  rtc_timekeeper_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(ALARM_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;
  state_t st, st_n;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] h_r, ah_r;
  logic [5:0] m_r, s_r, am_r;
  logic sp, err;
  logic tick, t_ok, t_bad, a_ok, a_bad, hit;
  assign tick  = presc == PW'(TICK_DIV - 1);
  assign t_ok  = bus.initial_time_valid && bus.initial_time_hh <= 5'd23 &&
                 bus.initial_time_mm <= 6'd59 && bus.initial_time_ss <= 6'd59;
  assign t_bad = bus.initial_time_valid && !t_ok;
  assign a_ok  = bus.alarm_valid && bus.alarm_hh <= 5'd23 && bus.alarm_mm <= 6'd59;
  assign a_bad = bus.alarm_valid && !a_ok;
  // sec_pulse marks the cycle after a tick, so a match here means the tick reached the alarm minute
  assign hit = sp && h_r == ah_r && m_r == am_r && s_r == 6'd0;
  // time of day, prescaler, second pulse and sticky load error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      h_r   <= '0;
      m_r   <= '0;
      s_r   <= '0;
      ah_r  <= '0;
      am_r  <= '0;
      sp    <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= a_bad || ((err || t_bad) && !t_ok);
      if (a_ok) begin
        ah_r <= bus.alarm_hh;
        am_r <= bus.alarm_mm;
      end
      if (t_ok) begin
        presc <= '0;
        h_r   <= bus.initial_time_hh;
        m_r   <= bus.initial_time_mm;
        s_r   <= bus.initial_time_ss;
        sp    <= 1'b0;
      end else if (tick) begin
        presc <= '0;
        sp    <= 1'b1;
        if (s_r == 6'd59) begin
          s_r <= '0;
          if (m_r == 6'd59) begin
            m_r <= '0;
            h_r <= (h_r == 5'd23) ? 5'd0 : h_r + 5'd1;
          end else m_r <= m_r + 6'd1;
        end else s_r <= s_r + 6'd1;
      end else begin
        presc <= presc + PW'(1);
        sp    <= 1'b0;
      end
    end
  end
  // alarm state and ring counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end
  // alarm transitions: disable dominates, ring ends on clear or after ALARM_LEN pulses
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (!bus.alarm_en) st_n = IDLE;
    else if (st == IDLE) st_n = ARMED;
    else if (st == ARMED) begin
      if (hit) begin
        st_n  = RINGING;
        cnt_n = '0;
      end
    end else if (bus.alarm_clear) st_n = ARMED;
    else if (sp) begin
      if (cnt == CW'(ALARM_LEN - 1)) st_n = ARMED;
      else cnt_n = cnt + CW'(1);
    end
  end
  assign bus.hh        = (MODE12 == 0) ? h_r :
                         (h_r == 5'd0) ? 5'd12 :
                         (h_r > 5'd12) ? h_r - 5'd12 : h_r;
  assign bus.pm        = (MODE12 != 0) && (h_r >= 5'd12);
  assign bus.mm        = m_r;
  assign bus.ss        = s_r;
  assign bus.sec_pulse = sp;
  assign bus.alarm     = st == RINGING;
  assign bus.load_err  = err;
endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per second; legal range >= 2.
REQ-002 Parameter MODE12, default 0, 0 = 24-hour display, 1 = 12-hour display with pm flag.
REQ-003 Parameter ALARM_LEN, default 60, seconds the alarm rings before auto-stop; legal range >= 1.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 initial_time_hh / initial_time_mm / initial_time_ss  in  5/6/6  time load value.
REQ-007 initial_time_valid  in  1  one-cycle load strobe for time.
REQ-008 alarm_hh / alarm_mm  in  5/6  alarm set value; alarm_valid  in  1  load strobe.
REQ-009 alarm_en  in  1  level, arms the alarm; alarm_clear  in  1  one-cycle stop strobe.
REQ-010 hh / mm / ss  out  5/6/6  current time (hh per display mode).
REQ-011 pm  out  1  afternoon flag, constant 0 when MODE12=0.
REQ-012 sec_pulse  out  1  one-cycle pulse per elapsed second.
REQ-013 alarm  out  1  ringing indicator; load_err  out  1  sticky out-of-range flag.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1; at the edge where it equals TICK_DIV-1 it returns to 0, sec_pulse is 1 for the following cycle, and the time advances by one second on that same edge.
REQ-015 Time is held internally as 24-hour; ss wraps 59->0 with carry to mm; mm wraps 59->0 with carry to hh; hh wraps 23->0.
REQ-016 Time load: initial_time_valid=1 with hh<=23, mm<=59, ss<=59 loads the time on that edge (visible next cycle), clears the prescaler, and clears load_err.
REQ-017 Out-of-range time or alarm load is ignored entirely and sets load_err=1; load_err holds until the next in-range time load or reset.
REQ-018 Load and tick on the same edge: load wins, no increment, prescaler to 0, no sec_pulse.
REQ-019 Alarm load: alarm_valid=1 with in-range values updates the alarm registers on that edge in any alarm state without changing the state.
REQ-020 Alarm FSM states IDLE, ARMED, RINGING; alarm=1 only in RINGING.
REQ-021 IDLE->ARMED when alarm_en=1; any state->IDLE when alarm_en=0 (highest priority after reset).
REQ-022 ARMED->RINGING on the edge after a tick that makes time equal alarm_hh:alarm_mm:00; a time load never triggers the alarm.
REQ-023 RINGING->ARMED on alarm_clear=1 or after ALARM_LEN sec_pulses counted from ring entry; alarm_clear in IDLE/ARMED has no effect.
REQ-024 A new match while RINGING does not restart the ring counter.
REQ-025 MODE12=1 output mapping: hh 0->12 pm=0; 1..11 unchanged pm=0; 12->12 pm=1; 13..23 -> hh-12 pm=1; hh/pm are combinational from the time registers.
REQ-026 MODE12=0: hh equals the internal hour, pm=0.

Reset
REQ-027 rst_n=0 sampled at an edge sets time 00:00:00, prescaler 0, ring counter 0, alarm registers 00:00, FSM IDLE, sec_pulse=0, alarm=0, load_err=0.
REQ-028 After reset the outputs read hh=0 pm=0 (MODE12=0) or hh=12 pm=0 (MODE12=1).
REQ-029 Reset mid-operation, including while RINGING or on a load edge, overrides all other inputs at that edge.

Verification (TICK_DIV=4, ALARM_LEN=3)
REQ-030 Load 12:35:00 -> next cycle 12:35:00; after 4 cycles sec_pulse=1 for one cycle and ss=1.
REQ-031 Load 23:59:58, wait 2 ticks -> 00:00:00; the intermediate value 23:59:59 is also checked.
REQ-032 Load hh=24 while time is 05:00:00 -> time unchanged, load_err=1; then load 01:00:00 -> load_err=0.
REQ-033 Alarm 12:36, alarm_en=1, time 12:35:59 -> alarm=1 one cycle after the tick to 12:36:00; alarm=0 after 3 further sec_pulses; repeat with alarm_clear after 1 pulse -> alarm=0 next cycle.
REQ-034 MODE12=1: load 13:05:00 -> hh=1 pm=1; load 00:10:00 -> hh=12 pm=0; load 12:00:00 -> hh=12 pm=1.
REQ-035 Reset asserted while RINGING and simultaneous with initial_time_valid -> next cycle all reset values, alarm=0, FSM IDLE.
